// File: rtl/cla_pkg.sv
// Shared definitions for the registered 4-bit carry-lookahead adder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: none; no flow control at this level.
//
// Contents:
//   CLA_WIDTH   - datapath width (fixed at 4)
//   nibble_t    - 4-bit operand/sum type
//   cla_carries - flat two-level lookahead carry vector c[4:0], with c[0] = carry-in
package cla_pkg;

  localparam int CLA_WIDTH = 4;

  typedef logic [CLA_WIDTH-1:0] nibble_t;

  // Every carry is a sum of products of p/g/c0, so no carry depends on
  // another carry. This keeps the depth constant rather than a ripple chain.
  function automatic logic [CLA_WIDTH:0] cla_carries(input nibble_t p,
                                                     input nibble_t g,
                                                     input logic    c0);
    logic [CLA_WIDTH:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/cla4_core.sv
// Combinational 4-bit carry-lookahead adder core.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports:
//   a, b   - 4-bit unsigned operands
//   cin    - carry-in
//   s      - sum bits [3:0]
//   cout   - carry-out (bit 4 of a + b + cin)
//   grp_p  - group propagate, present only with CLA_GROUP_PG_EN
//   grp_g  - group generate, present only with CLA_GROUP_PG_EN
// Optional feature macro: CLA_GROUP_PG_EN
module cla4_core
  import cla_pkg::*;
(
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [CLA_WIDTH-1:0] s,
  output logic                 cout
`ifdef CLA_GROUP_PG_EN
  ,
  output logic                 grp_p,
  output logic                 grp_g
`endif
);

  nibble_t            p;
  nibble_t            g;
  logic [CLA_WIDTH:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = cla_carries(p, g, cin);
    s    = p ^ c[CLA_WIDTH-1:0];
    cout = c[CLA_WIDTH];
  end

`ifdef CLA_GROUP_PG_EN
  // Group terms exclude the carry-in so that a higher-level lookahead unit
  // can combine them with its own carry into this nibble.
  always_comb begin
    grp_p = &p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
`endif

endmodule

// File: rtl/full_circuit_with_dff.sv
// Registered 4-bit CLA adder: input flops -> cla4_core -> output flops.
// Latency: 2 cycles (inputs sampled at edge k appear after edge k+1); one op per cycle.
// Backpressure: none; every cycle carries a valid operation.
//
// Ports:
//   clk     - system clock, rising-edge
//   rst     - asynchronous active-high reset, clears both register stages
//   A_in    - operand A (4-bit unsigned)
//   B_in    - operand B (4-bit unsigned)
//   Cin     - carry-in
//   S_out   - registered sum [3:0]
//   C4_out  - registered carry-out
//   P_out   - registered group propagate (only with CLA_GROUP_PG_EN)
//   G_out   - registered group generate  (only with CLA_GROUP_PG_EN)
// Optional feature macro: CLA_GROUP_PG_EN
module full_circuit_with_dff
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLA_WIDTH-1:0] A_in,
  input  logic [CLA_WIDTH-1:0] B_in,
  input  logic                 Cin,
  output logic [CLA_WIDTH-1:0] S_out,
  output logic                 C4_out
`ifdef CLA_GROUP_PG_EN
  ,
  output logic                 P_out,
  output logic                 G_out
`endif
);

  // Stage 1: operand capture
  nibble_t a_r;
  nibble_t b_r;
  logic    cin_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      cin_r <= 1'b0;
    end else begin
      a_r   <= A_in;
      b_r   <= B_in;
      cin_r <= Cin;
    end
  end

  // Combinational core between the register stages
  nibble_t s_c;
  logic    c4_c;
`ifdef CLA_GROUP_PG_EN
  logic    p_c;
  logic    g_c;
`endif

  cla4_core u_core (
    .a    (a_r),
    .b    (b_r),
    .cin  (cin_r),
    .s    (s_c),
    .cout (c4_c)
`ifdef CLA_GROUP_PG_EN
    ,
    .grp_p(p_c),
    .grp_g(g_c)
`endif
  );

  // Stage 2: result capture. Outputs come only from these flops, so they
  // never follow the inputs combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_out  <= '0;
      C4_out <= 1'b0;
    end else begin
      S_out  <= s_c;
      C4_out <= c4_c;
    end
  end

`ifdef CLA_GROUP_PG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      P_out <= 1'b0;
      G_out <= 1'b0;
    end else begin
      P_out <= p_c;
      G_out <= g_c;
    end
  end
`endif

endmodule

// File: tb/tb_full_circuit_with_dff.sv
// Self-checking bench for full_circuit_with_dff.
// Latency: expectations are delayed two cycles through a small expected-value pipe.
// Backpressure: none; a new vector is driven every cycle.
// Optional feature macro: CLA_GROUP_PG_EN (enables P_out/G_out checks).
module tb_full_circuit_with_dff;

  logic       clk;
  logic       rst;
  logic [3:0] A_in;
  logic [3:0] B_in;
  logic       Cin;
  logic [3:0] S_out;
  logic       C4_out;
`ifdef CLA_GROUP_PG_EN
  logic       P_out;
  logic       G_out;
`endif

  int n_vec;
  int n_bad;

  // Expected-result pipe: slot 0 = driven this cycle, slot 1 = last cycle.
  logic [4:0] pipe_exp [2];
  logic [1:0] pipe_pg  [2];
  logic       pipe_vld [2];

  full_circuit_with_dff dut (
    .clk   (clk),
    .rst   (rst),
    .A_in  (A_in),
    .B_in  (B_in),
    .Cin   (Cin),
    .S_out (S_out),
    .C4_out(C4_out)
`ifdef CLA_GROUP_PG_EN
    ,
    .P_out (P_out),
    .G_out (G_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  // Group P/G expectations from the operands alone: P when every bit
  // propagates, G when the nibble carries out with no carry-in.
  function automatic logic [1:0] pg_model(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum0;
    sum0 = {1'b0, a} + {1'b0, b};
    return {((a ^ b) == 4'hF), sum0[4]};
  endfunction

  // One cycle: at the falling edge check the result due from two cycles
  // ago, advance the pipe and drive the next vector.
  task automatic cycle(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [4:0] e, input logic v);
    @(negedge clk);
    if (pipe_vld[1]) begin
      chk(tag, {3'b000, C4_out, S_out}, {3'b000, pipe_exp[1]});
`ifdef CLA_GROUP_PG_EN
      chk({tag, "_pg"}, {6'd0, P_out, G_out}, {6'd0, pipe_pg[1]});
`endif
    end
    pipe_exp[1] = pipe_exp[0];
    pipe_pg[1]  = pipe_pg[0];
    pipe_vld[1] = pipe_vld[0];
    pipe_exp[0] = e;
    pipe_pg[0]  = pg_model(a, b);
    pipe_vld[0] = v;
    A_in = a;
    B_in = b;
    Cin  = c;
  endtask

  // Directed vectors: {A, B, Cin, expected {C4,S}} computed by hand.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] e;
  } vec_t;

  vec_t dir_tbl [5] = '{
    '{4'b0011, 4'b0101, 1'b0, 5'b0_1000},
    '{4'b1111, 4'b0001, 1'b1, 5'b1_0001},
    '{4'b0110, 4'b1001, 1'b1, 5'b1_0000},
    '{4'b1010, 4'b0101, 1'b0, 5'b0_1111},
    '{4'b1111, 4'b1111, 1'b1, 5'b1_1111}
  };

  vec_t str_tbl [20] = '{
    '{4'b1011, 4'b1001, 1'b1, 5'b1_0101},
    '{4'b0000, 4'b1110, 1'b0, 5'b0_1110},
    '{4'b0001, 4'b0001, 1'b0, 5'b0_0010},
    '{4'b0111, 4'b0111, 1'b1, 5'b0_1111},
    '{4'b1000, 4'b1000, 1'b0, 5'b1_0000},
    '{4'b1100, 4'b0011, 1'b1, 5'b1_0000},
    '{4'b0101, 4'b0101, 1'b0, 5'b0_1010},
    '{4'b1110, 4'b0001, 1'b0, 5'b0_1111},
    '{4'b1001, 4'b0110, 1'b0, 5'b0_1111},
    '{4'b0010, 4'b0100, 1'b1, 5'b0_0111},
    '{4'b1111, 4'b0000, 1'b0, 5'b0_1111},
    '{4'b1111, 4'b0000, 1'b1, 5'b1_0000},
    '{4'b0011, 4'b0011, 1'b1, 5'b0_0111},
    '{4'b1101, 4'b1011, 1'b0, 5'b1_1000},
    '{4'b0100, 4'b1100, 1'b1, 5'b1_0001},
    '{4'b0000, 4'b0000, 1'b1, 5'b0_0001},
    '{4'b1010, 4'b1010, 1'b1, 5'b1_0101},
    '{4'b0110, 4'b0011, 1'b0, 5'b0_1001},
    '{4'b1110, 4'b1110, 1'b1, 5'b1_1101},
    '{4'b0001, 4'b1111, 1'b0, 5'b1_0000}
  };

  task automatic clear_pipe();
    pipe_vld[0] = 1'b0;
    pipe_vld[1] = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] e;

    n_vec = 0;
    n_bad = 0;
    clear_pipe();
    pipe_exp[0] = '0; pipe_exp[1] = '0;
    pipe_pg[0]  = '0; pipe_pg[1]  = '0;
    A_in = 4'hF; B_in = 4'hF; Cin = 1'b1;
    rst  = 1'b1;

    // Reset state, with nonzero inputs present
    #1;
    chk("reset_init", {3'b000, C4_out, S_out}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", {3'b000, C4_out, S_out}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, streamed back to back
    foreach (dir_tbl[i])
      cycle("directed", dir_tbl[i].a, dir_tbl[i].b, dir_tbl[i].c, dir_tbl[i].e, 1'b1);
    // Streaming: 20 consecutive operands, in-order, no bubbles
    foreach (str_tbl[i])
      cycle("stream", str_tbl[i].a, str_tbl[i].b, str_tbl[i].c, str_tbl[i].e, 1'b1);

    // Mid-stream asynchronous reset with a nonzero result on the outputs
    cycle("pre_rst", 4'b1111, 4'b1111, 1'b1, 5'b1_1111, 1'b1);
    cycle("pre_rst", 4'b1111, 4'b1111, 1'b1, 5'b1_1111, 1'b1);
    cycle("pre_rst", 4'b1111, 4'b1111, 1'b1, 5'b1_1111, 1'b1);
    @(posedge clk);
    #2;
    chk("rst_before", {3'b000, C4_out, S_out}, 8'b0001_1111);
    rst = 1'b1;
    #1;
    chk("rst_async", {3'b000, C4_out, S_out}, 8'd0);
    @(posedge clk);
    #1;
    chk("rst_held", {3'b000, C4_out, S_out}, 8'd0);
    @(negedge clk);
    A_in = 4'h0; B_in = 4'h0; Cin = 1'b0;
    rst  = 1'b0;
    // Both in-flight operations were discarded: the next two results are zero.
    clear_pipe();
    pipe_exp[1] = 5'd0; pipe_pg[1] = 2'b00; pipe_vld[1] = 1'b1;
    pipe_exp[0] = 5'd0; pipe_pg[0] = 2'b00; pipe_vld[0] = 1'b1;

    // Exhaustive sweep against the behavioural sum
    for (int i = 0; i < 512; i++) begin
      a = i[8:5];
      b = i[4:1];
      c = i[0];
      e = {1'b0, a} + {1'b0, b} + {4'b0000, c};
      cycle("exhaustive", a, b, c, e, 1'b1);
    end
    // Drain the pipe
    cycle("drain", 4'h0, 4'h0, 1'b0, 5'd0, 1'b0);
    cycle("drain", 4'h0, 4'h0, 1'b0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
